// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one uart byte transmitter
// between NREQ valid/ready byte producers. It latches the winning byte, pulses
// the write strobe and follows the transmitter's busy flag until the frame is done.
// Optional feature: define UART_ARB_LOCK_EN to keep a grant on one requester
// until it sends a byte flagged with req_last.
module uart_tx_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NREQ-1:0]   req_last,
`endif
    output logic [NREQ-1:0]   req_ready,
    output logic              uart_wr,
    output logic [7:0]        uart_data,
    input  logic              uart_busy,
    output logic [2:0]        grant_id,
    output logic              active,
    output logic [15:0]       tx_count,
    output logic              stall_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

    state_t          state_q, state_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic [2:0]      grant_id_q, grant_id_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic            uart_wr_q, uart_wr_d;
    logic [7:0]      uart_data_q, uart_data_d;
    logic [15:0]     tx_count_q, tx_count_d;
    logic            stall_err_q, stall_err_d;
    logic            active_q, active_d;

    logic [7:0]      eligible;
    logic [63:0]     data_pad;
    logic [3:0]      idx;
    logic [2:0]      winner;
    logic [2:0]      next_ptr;
    logic            found;

`ifdef UART_ARB_LOCK_EN
    logic            lock_q, lock_d;
    logic [7:0]      last_pad;
`endif

    // Requesters allowed to compete this cycle; a locked message excludes everyone else.
    always_comb begin
        eligible = 8'(req_valid);
        data_pad = 64'(req_data);
`ifdef UART_ARB_LOCK_EN
        last_pad = 8'(req_last);
        if (lock_q) begin
            eligible = eligible & (8'b1 << grant_id_q);
        end
`endif
    end

    // Round-robin search: first eligible requester at or above rr_ptr, wrapping at NREQ.
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        idx    = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_ptr_q} + 4'(i);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end
            if (!found && eligible[idx[2:0]]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
        next_ptr = (winner == 3'(NREQ - 1)) ? 3'd0 : winner + 3'd1;
    end

    // Next-state logic; every output is computed here so it can be registered.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        req_ready_d = '0;
        uart_wr_d   = 1'b0;
        uart_data_d = uart_data_q;
        tx_count_d  = tx_count_q;
        stall_err_d = stall_err_q;
`ifdef UART_ARB_LOCK_EN
        lock_d      = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (found && !uart_busy) begin
                    state_d     = ISSUE;
                    grant_id_d  = winner;
                    uart_data_d = data_pad[{winner, 3'b000} +: 8];
                    uart_wr_d   = 1'b1;
                    tx_count_d  = tx_count_q + 16'd1;
                    for (int i = 0; i < NREQ; i++) begin
                        req_ready_d[i] = (winner == 3'(i));
                    end
`ifdef UART_ARB_LOCK_EN
                    if (last_pad[winner]) begin
                        lock_d   = 1'b0;
                        rr_ptr_d = next_ptr;
                    end else begin
                        lock_d   = 1'b1;
                    end
`else
                    rr_ptr_d = next_ptr;
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (uart_busy) begin
                    state_d = WAIT_LO;
                end else begin
                    stall_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            WAIT_LO: begin
                if (!uart_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        active_d = (state_d != IDLE);
    end

    // State and registered outputs; reset drops back to IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 3'd0;
            grant_id_q  <= 3'd0;
            req_ready_q <= '0;
            uart_wr_q   <= 1'b0;
            uart_data_q <= 8'h00;
            tx_count_q  <= 16'd0;
            stall_err_q <= 1'b0;
            active_q    <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            req_ready_q <= req_ready_d;
            uart_wr_q   <= uart_wr_d;
            uart_data_q <= uart_data_d;
            tx_count_q  <= tx_count_d;
            stall_err_q <= stall_err_d;
            active_q    <= active_d;
`ifdef UART_ARB_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign uart_wr   = uart_wr_q;
    assign uart_data = uart_data_q;
    assign grant_id  = grant_id_q;
    assign active    = active_q;
    assign tx_count  = tx_count_q;
    assign stall_err = stall_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized bench for uart_tx_arbiter with a
// behavioural transmitter and a round-robin reference model.
// Builds with or without UART_ARB_LOCK_EN.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int FRAME = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
    logic [NREQ-1:0]   req_last;
`endif
    logic [NREQ-1:0]   req_ready;
    logic              uart_wr;
    logic [7:0]        uart_data;
    logic              uart_busy;
    logic [2:0]        grant_id;
    logic              active;
    logic [15:0]       tx_count;
    logic              stall_err;

    int          checks = 0;
    int          errors = 0;
    int          model_ptr;
    logic [15:0] model_count;
    bit          model_lock;
    int          model_lock_id;
    bit          drop_mode;
    bit          rand_mode;
    int          busy_cnt;
    logic [7:0]  sent_data[$];
    int          sent_gid[$];

    uart_tx_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef UART_ARB_LOCK_EN
        .req_last  (req_last),
`endif
        .req_ready (req_ready),
        .uart_wr   (uart_wr),
        .uart_data (uart_data),
        .uart_busy (uart_busy),
        .grant_id  (grant_id),
        .active    (active),
        .tx_count  (tx_count),
        .stall_err (stall_err)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int idx, input logic [7:0] data, input logic valid);
        req_data[8*idx +: 8] = data;
        req_valid[idx]       = valid;
    endtask

    // Expected winner: first valid requester from the pointer, honouring a message lock.
    function automatic int pick(input logic [NREQ-1:0] v);
        int j;
        for (int k = 0; k < NREQ; k++) begin
            j = (model_ptr + k) % NREQ;
            if (v[j] === 1'b1 && (!model_lock || j == model_lock_id)) return j;
        end
        return -1;
    endfunction

    // One clock: scoreboard at the falling edge, then transmitter and requester models.
    task automatic cycle();
        int g;
        bit is_last;
        @(negedge clk);
        if (uart_wr === 1'b1) begin
            g = pick(req_valid);
            check_output("grant_exists", 32'(g >= 0), 1);
            if (g < 0) g = 0;
            check_output("no_grant_busy", 32'(uart_busy), 0);
            check_output("sb_grant_id", 32'(grant_id), 32'(g));
            check_output("sb_uart_data", 32'(uart_data), 32'(req_data[8*g +: 8]));
            check_output("sb_req_ready", 32'(req_ready), 32'(1 << g));
            check_output("sb_tx_count", 32'(tx_count), 32'(16'(model_count + 16'd1)));
            model_count = model_count + 16'd1;
            is_last = 1'b1;
`ifdef UART_ARB_LOCK_EN
            is_last = req_last[g];
`endif
            if (is_last) begin
                model_lock = 1'b0;
                model_ptr  = (g + 1) % NREQ;
            end else begin
                model_lock    = 1'b1;
                model_lock_id = g;
            end
            sent_data.push_back(uart_data);
            sent_gid.push_back(int'(grant_id));
        end else begin
            check_output("ready_idle", 32'(req_ready), 0);
        end
        if (uart_wr === 1'b1 && !drop_mode) begin
            busy_cnt  = FRAME;
            uart_busy = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) uart_busy = 1'b0;
        end
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] === 1'b1) begin
                    if ($urandom_range(1, 0) == 1) apply_stimulus(i, 8'($urandom), 1'b1);
                    else req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(3, 0) == 0) begin
                    apply_stimulus(i, 8'($urandom), 1'b1);
                end
`ifdef UART_ARB_LOCK_EN
                if (req_ready[i] === 1'b1 || !req_valid[i]) req_last[i] = 1'($urandom_range(1, 0));
`endif
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_output("rst_uart_wr", 32'(uart_wr), 0);
        check_output("rst_uart_data", 32'(uart_data), 0);
        check_output("rst_req_ready", 32'(req_ready), 0);
        check_output("rst_grant_id", 32'(grant_id), 0);
        check_output("rst_active", 32'(active), 0);
        check_output("rst_tx_count", 32'(tx_count), 0);
        check_output("rst_stall_err", 32'(stall_err), 0);
        cycle();
        rst         = 1'b0;
        model_ptr   = 0;
        model_count = 16'd0;
        model_lock  = 1'b0;
    endtask

    task automatic wait_wr(input string tag);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (uart_wr !== 1'b1 && n < 200);
        check_output({tag, "_wr_seen"}, 32'(uart_wr), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((active !== 1'b0 || uart_busy) && n < 300) begin
            cycle();
            n++;
        end
        check_output("idle_reached", 32'(active | uart_busy), 0);
    endtask

    // Directed scenarios followed by a randomized run, all checked by the scoreboard.
    initial begin
        logic [7:0] exp_data[5];
        int         exp_gid[5];
        int         n;
        rst = 1'b1; req_valid = '0; req_data = '0; uart_busy = 1'b0;
        busy_cnt = 0; drop_mode = 1'b0; rand_mode = 1'b0;
        model_ptr = 0; model_count = 16'd0; model_lock = 1'b0; model_lock_id = 0;
`ifdef UART_ARB_LOCK_EN
        req_last = '1;
`endif
        cycle();
        do_reset();

        $display("[TB] single request with one-cycle grant latency");
        apply_stimulus(0, 8'h41, 1'b1);
        cycle();
        check_output("single_latency_wr", 32'(uart_wr), 1);
        check_output("single_data", 32'(uart_data), 32'h41);
        check_output("single_ready", 32'(req_ready), 32'h1);
        check_output("single_count", 32'(tx_count), 1);
        check_output("single_active", 32'(active), 1);
        req_valid = '0;
        wait_idle();

        $display("[TB] reset during WAIT_LO");
        apply_stimulus(1, 8'h55, 1'b1);
        wait_wr("mid");
        req_valid = '0;
        cycle();
        cycle();
        check_output("mid_active_before", 32'(active), 1);
        check_output("mid_busy_before", 32'(uart_busy), 1);
        apply_stimulus(2, 8'h66, 1'b1);
        do_reset();
        n = 0;
        while (uart_busy && n < 50) begin
            check_output("mid_hold_while_busy", 32'(uart_wr), 0);
            cycle();
            n++;
        end
        wait_wr("mid_after");
        check_output("mid_after_gid", 32'(grant_id), 2);
        check_output("mid_after_data", 32'(uart_data), 32'h66);
        req_valid = '0;
        wait_idle();

        $display("[TB] pointer wrap from requester 3 to 0");
        apply_stimulus(3, 8'hD3, 1'b1);
        apply_stimulus(0, 8'hA0, 1'b1);
        wait_wr("wrap3");
        check_output("wrap_first_gid", 32'(grant_id), 3);
        check_output("wrap_first_data", 32'(uart_data), 32'hD3);
        req_valid[3] = 1'b0;
        wait_wr("wrap0");
        check_output("wrap_second_gid", 32'(grant_id), 0);
        check_output("wrap_second_data", 32'(uart_data), 32'hA0);
        req_valid = '0;
        wait_idle();
        do_reset();

        $display("[TB] four-way contention");
        exp_data = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
        exp_gid  = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) apply_stimulus(i, 8'(8'h10 * (i + 1)), 1'b1);
        for (int i = 0; i < 5; i++) begin
            wait_wr("cont");
            check_output("cont_data", 32'(uart_data), 32'(exp_data[i]));
            check_output("cont_gid", 32'(grant_id), 32'(exp_gid[i]));
        end
        req_valid = '0;
        wait_idle();

        $display("[TB] lost write sets sticky stall flag");
        drop_mode = 1'b1;
        apply_stimulus(0, 8'h77, 1'b1);
        wait_wr("stall");
        req_valid = '0;
        cycle();
        cycle();
        check_output("stall_set", 32'(stall_err), 1);
        check_output("stall_idle", 32'(active), 0);
        drop_mode = 1'b0;
        apply_stimulus(1, 8'h88, 1'b1);
        wait_wr("stall_next");
        check_output("stall_next_data", 32'(uart_data), 32'h88);
        req_valid = '0;
        wait_idle();
        check_output("stall_sticky", 32'(stall_err), 1);

        $display("[TB] transmit counter wrap");
        force dut.tx_count_q = 16'hFFFF;
        cycle();
        release dut.tx_count_q;
        model_count = 16'hFFFF;
        cycle();
        check_output("wrap_preload", 32'(tx_count), 32'hFFFF);
        apply_stimulus(2, 8'h99, 1'b1);
        wait_wr("cnt_wrap");
        check_output("cnt_wrap_zero", 32'(tx_count), 0);
        req_valid = '0;
        wait_idle();

`ifdef UART_ARB_LOCK_EN
        $display("[TB] message lock holds requester 1 for three bytes");
        do_reset();
        req_last = 4'b0100;
        apply_stimulus(1, 8'hB1, 1'b1);
        apply_stimulus(2, 8'hC2, 1'b1);
        wait_wr("lock1");
        check_output("lock_gid_1", 32'(grant_id), 1);
        apply_stimulus(1, 8'hB2, 1'b1);
        wait_wr("lock2");
        check_output("lock_gid_2", 32'(grant_id), 1);
        apply_stimulus(1, 8'hB3, 1'b1);
        req_last[1] = 1'b1;
        wait_wr("lock3");
        check_output("lock_gid_3", 32'(grant_id), 1);
        check_output("lock_data_3", 32'(uart_data), 32'hB3);
        req_valid[1] = 1'b0;
        wait_wr("lock_other");
        check_output("lock_gid_other", 32'(grant_id), 2);
        check_output("lock_data_other", 32'(uart_data), 32'hC2);
        req_valid = '0;
        wait_idle();
`endif

        $display("[TB] randomized traffic");
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) cycle();
        rand_mode = 1'b0;
        req_valid = '0;
        wait_idle();
        check_output("sent_log_nonempty", 32'(sent_data.size() > 20), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `uart` byte transmitter between NREQ byte-stream requesters. Each requester presents a byte with a valid/ready handshake. The arbiter grants one requester at a time, drives the transmitter's `wr`/`data` strobe, and tracks its `busy` flag until the byte leaves the line. It sits between the processor's debug, console and status producers and the `uart` instance.

## Interface
- `NREQ`, 4: number of requesters, legal range 2..8.
- `clk`  in  1: system clock; all logic is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: requester i has a byte pending; it holds `valid` and its data stable until `req_ready[i]`.
- `req_data`  in  8*NREQ: byte of requester i is at bits [8i+7:8i].
- `req_ready`  out  NREQ: one-hot, one-cycle pulse; the byte of requester i was accepted.
- `uart_wr`  out  1: write strobe to the transmitter's `wr`.
- `uart_data`  out  8: byte to the transmitter's `data`.
- `uart_busy`  in  1: the transmitter's `busy`.
- `grant_id`  out  3: index of the current or last granted requester.
- `active`  out  1: high whenever the state is not IDLE.
- `tx_count`  out  16: bytes issued, modulo 2^16.
- `stall_err`  out  1: sticky; set when the transmitter did not acknowledge a write.

## Operation
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO.
- IDLE:
  - Transition condition: any `req_valid` and `!uart_busy`.
  - Winner g is the first asserted `req_valid` searching upward from pointer `rr_ptr`, wrapping at NREQ.
  - Registered on that edge: `grant_id`←g, data latch←req_data[g]. Next state ISSUE.
- ISSUE, one cycle:
  - `uart_wr`=1, `uart_data`=latched byte, `req_ready[g]`=1.
  - `tx_count`+1, wrapping 0xFFFF→0x0000.
  - `rr_ptr`←(g+1) mod NREQ.
  - Next state WAIT_HI.
- WAIT_HI:
  - `uart_busy`=1 → WAIT_LO.
  - `uart_busy`=0 → set `stall_err`, return to IDLE. The transmitter raises busy exactly one cycle after `wr`, so a low here means the write was lost.
- WAIT_LO: stay while `uart_busy`=1; on `uart_busy`=0 → IDLE.
- `uart_wr` and `req_ready` are registered outputs, high only in ISSUE.
- `uart_data` holds its value outside ISSUE.
- A requester dropping `req_valid` after the grant edge does not cancel the byte. The byte was already latched and is still sent and acknowledged.
- Reset values:
  - state IDLE, `rr_ptr`=0, `grant_id`=0.
  - `uart_wr`=0, `uart_data`=0x00, `req_ready`=0.
  - `tx_count`=0, `stall_err`=0, `active`=0.
- Reset asserted mid-byte: the arbiter returns to IDLE at once. The transmitter finishes its own frame, and the arbiter waits on `uart_busy` low before the next grant.

## Timing
- Grant-to-strobe latency: valid seen in IDLE at edge N; `uart_wr` and `req_ready` are high in cycle N+1.
- Minimum spacing between successive `uart_wr` pulses: one full UART frame plus 3 cycles (WAIT_LO→IDLE, IDLE→ISSUE, ISSUE).
- If valid and busy are both high in IDLE, no grant is made until busy falls.
- A single requester alone is served back to back; fairness holds only among simultaneous requesters.

## Configuration
- `UART_ARB_LOCK_EN`:
  - Defined:
    - Adds input `req_last` (NREQ). Bit i marks requester i's byte as the final byte of a message.
    - After a grant to g, IDLE considers only requester g until a byte with `req_last[g]`=1 is accepted. Other requesters stall.
    - `rr_ptr` advances only on that last byte.
  - Undefined: the port is absent and every byte is arbitrated independently.

## Test plan
- Reset mid-WAIT_LO → all outputs at their reset values; the next grant occurs only after `uart_busy` falls.
- Single request: `req_valid`=0001, data0=0x41, busy idle → `uart_wr` pulse one cycle later with `uart_data`=0x41, `req_ready`=0001, `tx_count`=1.
- Contention: all four valid, data 0x10/0x20/0x30/0x40, held → bytes sent in order 0x10,0x20,0x30,0x40,0x10; `grant_id` sequence 0,1,2,3,0.
- Pointer wrap: `rr_ptr`=3, valid=1001 → requester 3 is served, then requester 0.
- Stall: model holds `uart_busy`=0 after `wr` → `stall_err`=1 and stays high; the arbiter returns to IDLE and accepts the next request.
- Count wrap: preload via 65535 sends or force → the next send gives `tx_count`=0x0000.
- With `UART_ARB_LOCK_EN`: requester 1 sends three bytes, last on the third, while requester 2 is valid → requester 2 is served only after the third byte.
